rs232_rx: RTL and testbench
===========================

Name: rs232_rx

Overview:
UART receiver paired with the existing rs232_tx: 1 start, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Uses the same baud divisor word and parity-select convention as the transmitter.
- Feeds received bytes to the DAC/ADC control logic over the board's serial link.
- Reports each completed frame with a one-cycle strobe plus parity and framing status.

Parameters:
- Width, 15, width of baud_i divisor word (clock cycles per bit).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- rx_i  in  1  serial line, asynchronous to clk_i, idle high
- baud_i  in  Width  clock cycles per bit; legal range 4 .. 2^Width-1
- psel_i  in  1  1 = parity bit present (even parity), 0 = no parity bit
- d_o  out  8  last received byte
- rdy_o  out  1  one-cycle strobe: frame complete, d_o/perr_o/ferr_o valid
- perr_o  out  1  parity error of last frame
- ferr_o  out  1  framing error (stop bit sampled 0) of last frame

Behaviour:
- Reset (async, rst_i=1): state IDLE, synchronizer flops = 1, counters = 0, d_o=8'h00, rdy_o=0, perr_o=0, ferr_o=0. Reset mid-frame aborts the frame with no rdy_o.
- rx_i passes through a 2-flop synchronizer (sync reset value 1); rxs is the second flop output. All sampling uses rxs.
- Start edge E = first cycle with rxs=0 while in IDLE.
- At E, latch baud_i → baud_q and psel_i → psel_q. Changes to baud_i/psel_i mid-frame are ignored.
- Bit counter: restartable down-counter loaded with baud_q>>1 at E, then with baud_q-1 after each sample. A sample happens when the counter reaches 0.
- Sample instants, with H = baud_q>>1 and N = baud_q:
  - start at E+H
  - data bit k (k=0..7) at E+H+(k+1)·N
  - parity at E+H+9·N
  - stop at E+H+9·N (psel_q=0) or E+H+10·N (psel_q=1)
- States:
  - IDLE: rxs=0 → START.
  - START: at sample, rxs=1 → IDLE (glitch rejected, no rdy_o); rxs=0 → DATA.
  - DATA: shift rxs into shift register MSB side, so bit 0 lands in LSB after 8 shifts. After 8th sample → PARITY if psel_q else STOP.
  - PARITY: store sampled bit → STOP.
  - STOP: at sample, update outputs → IDLE if rxs=1, BRK if rxs=0.
  - BRK: wait for rxs=1 → IDLE. Prevents a held-low line from retriggering.
- Output update, at the stop-sample cycle; registers take value the next cycle:
  - d_o ← shift register.
  - perr_o ← psel_q & (parity bit ≠ ^data), i.e. even parity.
  - ferr_o ← ~rxs.
  - rdy_o = 1 for exactly that one following cycle.
- d_o/perr_o/ferr_o hold until the next frame's update; no consumer handshake. An unread byte is overwritten silently.
- A frame with ferr_o=1 still delivers d_o and pulses rdy_o.
- Back-to-back frames: a new start edge is accepted in the cycle after the return to IDLE, i.e. the stop bit needs only half a bit time of high.
- baud_i < 4 is out of range; behaviour is undefined, no assertion is required.

Decomposition:
- Package rs232_pkg:
  - state encoding (IDLE, START, DATA, PARITY, STOP, BRK) as 3-bit localparams
  - DATA_BITS = 8
  - SYNC_STAGES = 2
- One sub-module, rx_baud_cnt:
  - loadable down-counter, Width bits
  - ports clk_i, rst_i, ld_i, val_i, tick_o
  - The existing freq_div is free-running and cannot be phase-aligned to the start edge, so it is not reused.
- The existing parity module is reused for the ^data computation.

Test Plan:
1. baud_i=16, psel_i=0, send 8'hA5 with valid stop → rdy_o single pulse at E+153, d_o=8'hA5, perr_o=0, ferr_o=0.
2. baud_i=16, psel_i=1, send 8'h3C with parity bit 1 (correct parity is 0) → rdy_o at E+169, d_o=8'h3C, perr_o=1, ferr_o=0. Repeat with parity bit 0 → perr_o=0.
3. baud_i=16, rx_i low for 3 cycles then high → no rdy_o, FSM back in IDLE. A following valid frame 8'h55 is received correctly.
4. baud_i=16, psel_i=0, send 8'hFF with stop bit 0, line held low 40 more cycles → rdy_o pulse, d_o=8'hFF, ferr_o=1. No second frame starts until rxs returns high.
5. baud_i=20, two back-to-back frames 8'h01 then 8'h80, each with a 1-bit stop → two rdy_o pulses 200 cycles apart, d_o=8'h01 then 8'h80.
6. Assert rst_i for 1 cycle during data bit 4 of a frame → outputs zero immediately and no rdy_o for that frame. The next full frame 8'hC3 is received correctly.

Source files
------------

// File: rtl/rs232_pkg.sv
// rs232_pkg: shared definitions for the RS-232 receiver.
//   - rx_state_e  : receiver FSM state encoding (3 bits)
//   - DATA_BITS   : payload bits per frame
//   - SYNC_STAGES : depth of the rx line synchronizer
//   - even_parity : XOR reduction of a data byte (1 = odd number of ones)
package rs232_pkg;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BRK    = 3'd5
    } rx_state_e;

    // Returns the bit that makes the byte plus parity bit hold an even
    // number of ones.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/rs232_rx_baud_cnt.sv
// rx_baud_cnt: loadable down-counter that times the bit sampling instants.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset (counter cleared)
//   ld_i   : load val_i into the counter this cycle
//   val_i  : reload value
//   tick_o : high while the counter sits at zero
// The counter stops at zero until reloaded, so a load of V produces the next
// tick V+1 cycles after the loading cycle.
module rx_baud_cnt #(
    parameter int Width = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_i,
    input  logic [Width-1:0] val_i,
    output logic             tick_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/rs232_rx.sv
// rs232_rx: UART receiver, 1 start bit, 8 data bits LSB first, optional even
// parity bit, 1 stop bit. Each completed frame is reported with a one-cycle
// rdy_o strobe together with the byte and its parity/framing status.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset
//   rx_i   : serial line, asynchronous to clk_i, idle high
//   baud_i : clock cycles per bit (4 .. 2^Width-1), latched at the start edge
//   psel_i : 1 = parity bit present (even parity), latched at the start edge
//   d_o    : last received byte
//   rdy_o  : one-cycle strobe, d_o/perr_o/ferr_o updated
//   perr_o : parity error of the last frame
//   ferr_o : framing error (stop bit sampled low) of the last frame
module rs232_rx
    import rs232_pkg::*;
#(
    parameter int Width = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_i,
    input  logic [Width-1:0] baud_i,
    input  logic             psel_i,
    output logic [7:0]       d_o,
    output logic             rdy_o,
    output logic             perr_o,
    output logic             ferr_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    rx_state_e              state_q, state_d;
    logic [Width-1:0]       baud_q, baud_d;
    logic                   psel_q, psel_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   dat_q, dat_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   rdy_q, rdy_d;

    logic                   cnt_ld;
    logic [Width-1:0]       cnt_val;
    logic                   tick;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    rx_baud_cnt #(
        .Width (Width)
    ) u_baud_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .ld_i   (cnt_ld),
        .val_i  (cnt_val),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        psel_d  = psel_q;
        shift_d = shift_q;
        par_d   = par_q;
        bit_d   = bit_q;
        dat_d   = dat_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        rdy_d   = 1'b0;
        cnt_ld  = 1'b0;
        // A load of V ticks V+1 cycles later, so loading N-1 spaces samples
        // exactly one bit time apart.
        cnt_val = baud_q - Width'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    baud_d  = baud_i;
                    psel_d  = psel_i;
                    cnt_ld  = 1'b1;
                    // First sample half a bit after the start edge; baud_q is
                    // not yet valid in this cycle, so use baud_i directly.
                    cnt_val = (baud_i >> 1) - Width'(1);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rxs) begin
                        // Start bit gone by mid-bit: treat as a glitch.
                        state_d = ST_IDLE;
                    end else begin
                        bit_d   = 3'd0;
                        cnt_ld  = 1'b1;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'd1;
                    cnt_ld  = 1'b1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = psel_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    par_d   = rxs;
                    cnt_ld  = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    dat_d   = shift_q;
                    perr_d  = psel_q & (par_q != even_parity(shift_q));
                    ferr_d  = ~rxs;
                    rdy_d   = 1'b1;
                    // A low stop bit means a held-low line; wait for it to go
                    // high before arming for the next start edge.
                    state_d = rxs ? ST_IDLE : ST_BRK;
                end
            end
            ST_BRK: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            psel_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            bit_q   <= 3'd0;
            dat_q   <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            psel_q  <= psel_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            bit_q   <= bit_d;
            dat_q   <= dat_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            rdy_q   <= rdy_d;
        end
    end

    assign d_o    = dat_q;
    assign rdy_o  = rdy_q;
    assign perr_o = perr_q;
    assign ferr_o = ferr_q;

endmodule

// File: tb/tb_rs232_rx.sv
// Self-checking bench for rs232_rx. Frames are driven bit by bit on rx_i and
// the expected report (cycle of the rdy_o strobe, byte, parity and framing
// flags) is computed from the frame timing rules at drive time.
module tb_rs232_rx;

    localparam int W = 15;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         rx_i;
    logic [W-1:0] baud_i;
    logic         psel_i;
    logic [7:0]   d_o;
    logic         rdy_o;
    logic         perr_o;
    logic         ferr_o;

    rs232_rx #(.Width(W)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .rx_i   (rx_i),
        .baud_i (baud_i),
        .psel_i (psel_i),
        .d_o    (d_o),
        .rdy_o  (rdy_o),
        .perr_o (perr_o),
        .ferr_o (ferr_o)
    );

    always #5 clk = ~clk;

    // Cycle label: value during the cycle following each rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [7:0] d;
        logic       perr;
        logic       ferr;
    } ev_t;

    ev_t got_q[$];
    ev_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record every strobe as seen mid-cycle.
    always @(negedge clk) begin
        if (rdy_o === 1'b1) got_q.push_back('{cyc, d_o, perr_o, ferr_o});
    end

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic drive_bit(input logic b, input int n);
        rx_i = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] b, input int n, input logic psel,
                              input logic pbit, input logic stopb, input int extra_low);
        ev_t ev;
        baud_i = W'(n);
        psel_i = psel;
        // rx_i changes in this cycle; the receiver sees it two cycles later.
        ev.t    = cyc + 2 + n / 2 + (psel ? 10 : 9) * n + 1;
        ev.d    = b;
        ev.perr = psel & (pbit != (^b));
        ev.ferr = ~stopb;
        exp_q.push_back(ev);
        drive_bit(1'b0, n);
        // Settings changed after the start edge must not affect this frame.
        baud_i = W'($urandom_range(4, 60));
        psel_i = 1'($urandom_range(0, 1));
        for (int k = 0; k < 8; k++) drive_bit(b[k], n);
        if (psel) drive_bit(pbit, n);
        drive_bit(stopb, n);
        if (extra_low > 0) drive_bit(1'b0, extra_low);
    endtask

    task automatic compare(input string tag);
        int m;
        check({tag, " count"}, got_q.size(), exp_q.size());
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            $display("txn %s[%0d]: d=%02h perr=%0d ferr=%0d at cycle %0d (want %02h %0d %0d at %0d)",
                     tag, i, got_q[i].d, got_q[i].perr, got_q[i].ferr, got_q[i].t,
                     exp_q[i].d, exp_q[i].perr, exp_q[i].ferr, exp_q[i].t);
            check({tag, " time"}, got_q[i].t, exp_q[i].t);
            check({tag, " data"}, got_q[i].d, exp_q[i].d);
            check({tag, " perr"}, got_q[i].perr, exp_q[i].perr);
            check({tag, " ferr"}, got_q[i].ferr, exp_q[i].ferr);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        int         n;
        int         gap;
        logic       psel, pbit, stopb;

        rst_i  = 1'b1;
        rx_i   = 1'b1;
        baud_i = W'(16);
        psel_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset d_o", d_o, 8'h00);
        check("reset rdy_o", rdy_o, 1'b0);
        check("reset perr_o", perr_o, 1'b0);
        check("reset ferr_o", ferr_o, 1'b0);
        rst_i = 1'b0;
        idle(10);

        // Plain frame, no parity.
        send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b1, 0);
        idle(40);
        compare("a5_nopar");

        // Parity wrong, then parity right.
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 0);
        idle(40);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 0);
        idle(40);
        compare("3c_par");

        // Short glitch must be rejected; a following frame still works.
        baud_i = W'(16);
        psel_i = 1'b0;
        drive_bit(1'b0, 3);
        idle(60);
        compare("glitch");
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1, 0);
        idle(40);
        compare("after_glitch");

        // Framing error with the line held low afterwards.
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b0, 40);
        idle(60);
        compare("break");

        // Back-to-back frames at 20 cycles per bit.
        send_frame(8'h01, 20, 1'b0, 1'b0, 1'b1, 0);
        send_frame(8'h80, 20, 1'b0, 1'b0, 1'b1, 0);
        idle(50);
        compare("b2b");

        // Reset during data bit 4 aborts the frame.
        baud_i = W'(16);
        psel_i = 1'b0;
        b = 8'h96;
        drive_bit(1'b0, 16);
        for (int k = 0; k < 4; k++) drive_bit(b[k], 16);
        drive_bit(b[4], 8);
        rst_i = 1'b1;
        #1;
        check("midrst d_o", d_o, 8'h00);
        check("midrst perr_o", perr_o, 1'b0);
        check("midrst ferr_o", ferr_o, 1'b0);
        check("midrst rdy_o", rdy_o, 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        idle(200);
        compare("midrst");
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1, 0);
        idle(40);
        compare("after_rst");

        // Randomized frames against the timing/flag model.
        for (int i = 0; i < 24; i++) begin
            n     = $urandom_range(4, 40);
            b     = 8'($urandom);
            psel  = 1'($urandom_range(0, 1));
            pbit  = (^b) ^ ($urandom_range(0, 3) == 0);
            stopb = ($urandom_range(0, 4) != 0);
            send_frame(b, n, psel, pbit, stopb, stopb ? 0 : int'($urandom_range(0, 30)));
            gap = $urandom_range(stopb ? 0 : 2, 5);
            if (gap > 0) idle(gap);
        end
        idle(100);
        compare("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
